// File: rtl/rs_encoder_stream.sv
// rs_encoder_stream
// -----------------------------------------------------------------------------
// Streaming systematic Reed-Solomon encoder over GF(2^M). Message symbols are
// forwarded through a single output register while a parity LFSR divides the
// message by the generator polynomial g(x). The 2T parity symbols are emitted
// directly after the last message symbol, so no message buffer is required.
//
// Optional feature macro: RS_SHORTEN_EN
//   defined   : msg_len port present, per-block length 1..K sampled with the
//               first symbol; illegal lengths (0 or > K) fall back to K and
//               pulse len_err.
//   undefined : msg_len absent, every block is K symbols, len_err stays 0.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   s_data   in   M-bit message symbol
//   s_valid  in   s_data valid
//   s_ready  out  encoder accepts s_data this cycle
//   msg_len  in   LW-bit block length (RS_SHORTEN_EN only)
//   m_data   out  M-bit codeword symbol
//   m_valid  out  m_data valid
//   m_ready  in   downstream accepts m_data
//   m_parity out  m_data is a parity symbol
//   m_last   out  m_data is the last symbol of the codeword
//   busy     out  a block is open
//   len_err  out  one-cycle pulse: sampled msg_len was illegal
// -----------------------------------------------------------------------------
module rs_encoder_stream #(
    parameter int M         = 8,
    parameter int N         = 255,
    parameter int K         = 223,
    parameter int PRIM_POLY = 285,
    parameter int FCR       = 0,
    parameter int LW        = $clog2(K + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [M-1:0]  s_data,
    input  logic          s_valid,
    output logic          s_ready,
`ifdef RS_SHORTEN_EN
    input  logic [LW-1:0] msg_len,
`endif
    output logic [M-1:0]  m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_parity,
    output logic          m_last,
    output logic          busy,
    output logic          len_err
);

    localparam int T2 = N - K;
    localparam int PW = (T2 > 1) ? $clog2(T2) : 1;
    // Field polynomial without its x^M term; used when a shift overflows.
    localparam logic [M-1:0] POLY_LOW = M'(PRIM_POLY);

    // Multiply by alpha (x) in GF(2^M).
    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY_LOW : {M{1'b0}});
    endfunction

    // General GF(2^M) multiply; with one operand constant it folds to XORs.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] x;
        p = {M{1'b0}};
        x = a;
        for (int k = 0; k < M; k++) begin
            p = p ^ (b[k] ? x : {M{1'b0}});
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // g(x) = prod (x + alpha^(FCR+i)); returns g_0..g_{2T-1} (monic term dropped).
    function automatic logic [T2*M-1:0] gen_poly();
        logic [T2:0][M-1:0] g;
        logic [M-1:0]       root;
        logic [T2*M-1:0]    res;
        g    = '0;
        g[0] = M'(1);
        root = M'(1);
        res  = '0;
        for (int k = 0; k < FCR; k++) begin
            root = gf_xtime(root);
        end
        for (int i = 0; i < T2; i++) begin
            for (int j = i + 1; j >= 1; j--) begin
                g[j] = g[j-1] ^ gf_mul(g[j], root);
            end
            g[0] = gf_mul(g[0], root);
            root = gf_xtime(root);
        end
        for (int j = 0; j < T2; j++) begin
            res[j*M +: M] = g[j];
        end
        return res;
    endfunction

    localparam logic [T2*M-1:0] G_COEF = gen_poly();

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MSG    = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [M-1:0]  lfsr_r     [0:T2-1];
    logic [M-1:0]  lfsr_s     [0:T2-1];
    logic [M-1:0]  lfsr_upd_s [0:T2-1];
    logic [M-1:0]  fb_s;
    logic [LW-1:0] sym_cnt_r, sym_cnt_s, sym_next_s;
    logic [LW-1:0] blk_len_r, blk_len_s;
    logic [LW-1:0] first_len_s, cur_len_s;
    logic [PW-1:0] par_cnt_r, par_cnt_s;
    logic [M-1:0]  m_data_r, m_data_s;
    logic          m_valid_r, m_valid_s;
    logic          m_parity_r, m_parity_s;
    logic          m_last_r, m_last_s;
    logic          len_err_r, len_err_s;
    logic          len_bad_s;
    logic          load_en_s, in_xfer_s, last_msg_s;

`ifdef RS_SHORTEN_EN
    assign len_bad_s   = (msg_len == {LW{1'b0}}) || (msg_len > LW'(K));
    assign first_len_s = len_bad_s ? LW'(K) : msg_len;
`else
    assign len_bad_s   = 1'b0;
    assign first_len_s = LW'(K);
`endif

    // Output register may take a new symbol when empty or being drained.
    assign load_en_s  = !m_valid_r || m_ready;
    // rst gates s_ready so it reads 0 for the whole time reset is held.
    assign s_ready    = rst && (state_r != ST_PARITY) && load_en_s;
    assign in_xfer_s  = s_valid && s_ready;
    // In IDLE the length is not latched yet, so use the value being sampled.
    assign cur_len_s  = (state_r == ST_IDLE) ? first_len_s : blk_len_r;
    assign sym_next_s = sym_cnt_r + LW'(1);
    assign last_msg_s = (sym_next_s == cur_len_s);

    // LFSR contents after a message transfer; a new block starts from zero.
    always_comb begin
        fb_s          = s_data ^ ((state_r == ST_IDLE) ? {M{1'b0}} : lfsr_r[T2-1]);
        lfsr_upd_s[0] = gf_mul(fb_s, G_COEF[M-1:0]);
        for (int i = 1; i < T2; i++) begin
            lfsr_upd_s[i] = ((state_r == ST_IDLE) ? {M{1'b0}} : lfsr_r[i-1])
                            ^ gf_mul(fb_s, G_COEF[i*M +: M]);
        end
    end

    // Next-state, counters, LFSR and output register contents.
    always_comb begin
        state_s    = state_r;
        lfsr_s     = lfsr_r;
        sym_cnt_s  = sym_cnt_r;
        blk_len_s  = blk_len_r;
        par_cnt_s  = par_cnt_r;
        m_data_s   = m_data_r;
        m_valid_s  = m_valid_r;
        m_parity_s = m_parity_r;
        m_last_s   = m_last_r;
        len_err_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_MSG: begin
                if (in_xfer_s) begin
                    lfsr_s     = lfsr_upd_s;
                    m_data_s   = s_data;
                    m_valid_s  = 1'b1;
                    m_parity_s = 1'b0;
                    m_last_s   = 1'b0;
                    if (state_r == ST_IDLE) begin
                        blk_len_s = first_len_s;
                        len_err_s = len_bad_s;
                    end else begin
                        blk_len_s = blk_len_r;
                    end
                    if (last_msg_s) begin
                        state_s   = ST_PARITY;
                        sym_cnt_s = {LW{1'b0}};
                    end else begin
                        state_s   = ST_MSG;
                        sym_cnt_s = sym_next_s;
                    end
                end else if (m_valid_r && m_ready) begin
                    m_valid_s = 1'b0;
                end else begin
                    m_valid_s = m_valid_r;
                end
            end
            ST_PARITY: begin
                if (load_en_s) begin
                    m_data_s   = lfsr_r[T2-1];
                    m_valid_s  = 1'b1;
                    m_parity_s = 1'b1;
                    lfsr_s[0]  = {M{1'b0}};
                    for (int i = 1; i < T2; i++) begin
                        lfsr_s[i] = lfsr_r[i-1];
                    end
                    if (par_cnt_r == PW'(T2 - 1)) begin
                        m_last_s  = 1'b1;
                        par_cnt_s = {PW{1'b0}};
                        state_s   = ST_IDLE;
                    end else begin
                        m_last_s  = 1'b0;
                        par_cnt_s = par_cnt_r + PW'(1);
                    end
                end else begin
                    m_valid_s = m_valid_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, LFSR, counters and output register; reset abandons any block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            for (int i = 0; i < T2; i++) begin
                lfsr_r[i] <= {M{1'b0}};
            end
            sym_cnt_r  <= {LW{1'b0}};
            blk_len_r  <= {LW{1'b0}};
            par_cnt_r  <= {PW{1'b0}};
            m_data_r   <= {M{1'b0}};
            m_valid_r  <= 1'b0;
            m_parity_r <= 1'b0;
            m_last_r   <= 1'b0;
            len_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            lfsr_r     <= lfsr_s;
            sym_cnt_r  <= sym_cnt_s;
            blk_len_r  <= blk_len_s;
            par_cnt_r  <= par_cnt_s;
            m_data_r   <= m_data_s;
            m_valid_r  <= m_valid_s;
            m_parity_r <= m_parity_s;
            m_last_r   <= m_last_s;
            len_err_r  <= len_err_s;
        end
    end

    assign m_data   = m_data_r;
    assign m_valid  = m_valid_r;
    assign m_parity = m_parity_r;
    assign m_last   = m_last_r;
    assign busy     = (state_r != ST_IDLE);
    assign len_err  = len_err_r;

endmodule

// File: tb/tb_rs_encoder_stream.sv
// tb_rs_encoder_stream
// Directed bench for rs_encoder_stream with default RS(255,223) parameters.
// Expected codewords come from a log/antilog GF model doing polynomial long
// division; every codeword is also checked for zero syndromes at all 2T roots.
module tb_rs_encoder_stream;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] msg_len;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_parity;
    logic       m_last;
    logic       busy;
    logic       len_err;

    rs_encoder_stream dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
`ifdef RS_SHORTEN_EN
        .msg_len  (msg_len),
`endif
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_parity (m_parity),
        .m_last   (m_last),
        .busy     (busy),
        .len_err  (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int        exp_t [0:254];
    int        log_t [0:255];
    int        gb    [0:32];
    bit [7:0]  msg   [0:222];
    bit [7:0]  cw    [0:254];

    logic [7:0] oq [$];
    bit         pq [$];
    bit         lq [$];
    int         cq [$];
    int         cyc = 0;
    int         len_err_seen = 0;
    bit         in_acc = 1'b0;
    bit         stall_pend = 1'b0;
    logic [7:0] stall_d;
    logic       stall_p;
    logic       stall_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    // One clock: sample outputs at the falling edge, advance past the rising edge.
    task automatic step();
        @(negedge clk);
        if (stall_pend) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, stall_d);
            chk("stall_parity", m_parity, stall_p);
            chk("stall_last", m_last, stall_l);
        end
        stall_pend = m_valid && !m_ready;
        stall_d = m_data;
        stall_p = m_parity;
        stall_l = m_last;
        if (m_valid && m_ready) begin
            oq.push_back(m_data);
            pq.push_back(m_parity);
            lq.push_back(m_last);
            cq.push_back(cyc);
        end
        if (len_err) len_err_seen++;
        in_acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Stream nblk copies of msg[0..len-1]; lenfield is what msg_len carries.
    task automatic run_blocks(input int nblk, input int len, input int lenfield, input bit rnd);
        int idx;
        int blk;
        oq.delete(); pq.delete(); lq.delete(); cq.delete();
        len_err_seen = 0;
        idx = 0;
        blk = 0;
        for (int c = 0; c < 6000 && oq.size() < nblk * (len + 32); c++) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            msg_len = 8'(lenfield);
            if (blk < nblk) begin
                s_valid = 1'b1;
                s_data  = msg[idx];
            end else begin
                s_valid = 1'b0;
            end
            step();
            if (in_acc) begin
                idx++;
                if (idx == len) begin
                    idx = 0;
                    blk++;
                end
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("out_count", oq.size(), nblk * (len + 32));
    endtask

    // Long division of msg(x)*x^32 by g(x) fills cw with the expected codeword.
    task automatic build_expected(input int len);
        int w [0:254];
        for (int i = 0; i < len + 32; i++) w[i] = (i < len) ? int'(msg[i]) : 0;
        for (int i = 0; i < len; i++) begin
            int coef;
            coef = w[i];
            for (int j = 1; j <= 32; j++) w[i+j] = w[i+j] ^ gmul(coef, gb[32-j]);
        end
        for (int i = 0; i < len; i++) cw[i] = msg[i];
        for (int i = 0; i < 32; i++) cw[len+i] = 8'(w[len+i]);
    endtask

    task automatic check_blocks(input int nblk, input int len);
        build_expected(len);
        if (oq.size() >= nblk * (len + 32)) begin
            for (int b = 0; b < nblk; b++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < len + 32; k++) begin
                    int q;
                    q = b * (len + 32) + k;
                    chk($sformatf("cw_data[%0d]", q), oq[q], cw[k]);
                    chk($sformatf("cw_parity[%0d]", q), pq[q], (k >= len) ? 1 : 0);
                    chk($sformatf("cw_last[%0d]", q), lq[q], (k == len + 31) ? 1 : 0);
                end
                for (int r = 0; r < 32; r++) begin
                    int s;
                    s = 0;
                    for (int k = 0; k < len + 32; k++) begin
                        s = gmul(s, exp_t[r % 255]) ^ int'(oq[b * (len + 32) + k]);
                    end
                    acc = acc | s;
                end
                chk($sformatf("syndrome_blk%0d", b), acc, 0);
            end
        end
    endtask

    task automatic check_gen_parity(input int len);
        if (oq.size() >= len + 32) begin
            for (int j = 0; j < 32; j++) begin
                chk($sformatf("gen_coef[%0d]", 31 - j), oq[len + j], gb[31 - j]);
            end
        end
    endtask

    initial begin
        int x;
        rst = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        m_ready = 1'b1;
        msg_len = 8'd0;

        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 285;
        end
        log_t[0] = 0;
        for (int j = 0; j <= 32; j++) gb[j] = 0;
        gb[0] = 1;
        for (int i = 0; i < 32; i++) begin
            for (int j = i + 1; j >= 1; j--) gb[j] = gb[j-1] ^ gmul(gb[j], exp_t[i]);
            gb[0] = gmul(gb[0], exp_t[i]);
        end

        // Reset values while rst is held low.
        #3;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_parity", m_parity, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rel_s_ready", s_ready, 1);
        chk("rel_busy", busy, 0);
        @(posedge clk);
        #1;

        // All-zero full block.
        for (int i = 0; i < 223; i++) msg[i] = 8'h00;
        run_blocks(1, 223, 223, 1'b0);
        check_blocks(1, 223);
        chk("zero_len_err_count", len_err_seen, 0);
        @(negedge clk);
        chk("zero_busy_after", busy, 0);
        @(posedge clk);
        #1;

        // 222 zeros then 0x01: parity is the generator polynomial.
        msg[222] = 8'h01;
        run_blocks(1, 223, 223, 1'b0);
        check_blocks(1, 223);
        check_gen_parity(223);

        // Random message with 50% downstream backpressure.
        for (int i = 0; i < 223; i++) msg[i] = 8'($urandom_range(0, 255));
        run_blocks(1, 223, 223, 1'b1);
        check_blocks(1, 223);

`ifdef RS_SHORTEN_EN
        // Single-symbol shortened block.
        msg[0] = 8'h01;
        run_blocks(1, 1, 1, 1'b0);
        check_blocks(1, 1);
        check_gen_parity(1);

        // Illegal lengths fall back to K and flag len_err once per block.
        for (int i = 0; i < 223; i++) msg[i] = 8'h00;
        run_blocks(1, 223, 0, 1'b0);
        chk("len0_err_count", len_err_seen, 1);
        check_blocks(1, 223);
        run_blocks(1, 223, 224, 1'b0);
        chk("len224_err_count", len_err_seen, 1);
        check_blocks(1, 223);
`endif

        // Reset in the middle of a block, then two back-to-back blocks.
        for (int i = 0; i < 223; i++) msg[i] = 8'($urandom_range(0, 255));
        begin
            int idx;
            idx = 0;
            m_ready = 1'b1;
            msg_len = 8'd223;
            for (int c = 0; c < 400 && idx < 100; c++) begin
                s_valid = 1'b1;
                s_data  = msg[idx];
                step();
                if (in_acc) idx++;
            end
            chk("mid_accepted", idx, 100);
            chk("mid_busy", busy, 1);
        end
        #2 rst = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_m_parity", m_parity, 0);
        chk("midrst_m_last", m_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_len_err", len_err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        stall_pend = 1'b0;
        chk("post_rst_s_ready", s_ready, 1);
        run_blocks(2, 223, 223, 1'b0);
        check_blocks(2, 223);
        if (cq.size() == 510) begin
            chk("b2b_span", cq[509] - cq[0], 509);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
